// File: rtl/ipbase_fifo_pkg.sv
// Shared helpers for the first-word-fall-through FIFO: counter widths and
// legality checks for the parameter set.
package ipbase_fifo_pkg;

  localparam int MAX_READ_LATENCY = 4;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Capacity must be a power of two so the pointers wrap for free.
  function automatic bit depth_legal(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit latency_legal(input int read_latency);
    return (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY);
  endfunction

  function automatic bit thresh_legal(input int depth, input int pf, input int pe);
    return (pf >= 0) && (pf <= depth) && (pe >= 0) && (pe <= depth);
  endfunction

endpackage

// File: rtl/ipbase_sdpram_sync.sv
// Simple dual-port RAM, common clock: port A writes, port B reads with a
// READ_LATENCY_B-stage output pipeline. Contents are never reset.
module ipbase_sdpram_sync #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH_A   = 6,
  parameter int ADDR_WIDTH_B   = 6,
  parameter int READ_LATENCY_B = 2
) (
  input  logic                    clk,
  input  logic                    wea,
  input  logic [ADDR_WIDTH_A-1:0] addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic                    enb,
  input  logic [ADDR_WIDTH_B-1:0] addrb,
  output logic [DATA_WIDTH-1:0]   doutb
);

  logic [DATA_WIDTH-1:0] mem  [2**ADDR_WIDTH_A];
  logic [DATA_WIDTH-1:0] pipe [READ_LATENCY_B];

  // Write port A.
  always_ff @(posedge clk) begin
    if (wea) begin
      mem[addra] <= dina;
    end
  end

  // Read port B: first stage captures on enable, later stages shift every clock.
  always_ff @(posedge clk) begin
    if (enb) begin
      pipe[0] <= mem[addrb];
    end
    for (int k = 1; k < READ_LATENCY_B; k++) begin
      pipe[k] <= pipe[k-1];
    end
  end

  assign doutb = pipe[READ_LATENCY_B-1];

endmodule

// File: rtl/ipbase_fifo_fwft_sync.sv
// Synchronous FWFT FIFO: RAM storage plus a small register skid buffer that
// absorbs the RAM read latency so the head word is always presented directly.
module ipbase_fifo_fwft_sync
  import ipbase_fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 64,
  parameter int READ_LATENCY      = 2,
  parameter int PROG_FULL_THRESH  = DEPTH - 4,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         prog_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         prog_empty,
  output logic [$clog2(DEPTH+1)-1:0]   data_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = count_width(DEPTH);
  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int SKID_PW    = $clog2(SKID_DEPTH);
  localparam int SKID_CW    = count_width(SKID_DEPTH);
  localparam int CMW        = SKID_CW + 1;

  if (!(depth_legal(DEPTH) && latency_legal(READ_LATENCY) &&
        thresh_legal(DEPTH, PROG_FULL_THRESH, PROG_EMPTY_THRESH))) begin : g_param_error
    $error("ipbase_fifo_fwft_sync: illegal parameter set");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_pending;
  logic [CW-1:0]         ram_avail;
  logic [CW-1:0]         count_next;
  logic [READ_LATENCY-1:0] vld;
  logic [SKID_CW-1:0]    inflight;
  logic [SKID_CW-1:0]    skid_count;
  logic [SKID_CW-1:0]    skid_count_next;
  logic [SKID_PW-1:0]    skid_wr;
  logic [SKID_PW-1:0]    skid_rd;
  logic [CMW-1:0]        committed;
  logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  wr_accept;
  logic                  pop;
  logic                  issue;
  logic                  skid_push;

  function automatic logic [SKID_PW-1:0] skid_inc(input logic [SKID_PW-1:0] p);
    if (p == SKID_PW'(SKID_DEPTH - 1)) begin
      return {SKID_PW{1'b0}};
    end else begin
      return p + SKID_PW'(1'b1);
    end
  endfunction

  ipbase_sdpram_sync #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH_A  (AW),
    .ADDR_WIDTH_B  (AW),
    .READ_LATENCY_B(READ_LATENCY)
  ) u_ram (
    .clk  (clk),
    .wea  (wr_accept),
    .addra(wr_ptr),
    .dina (wr_data),
    .enb  (issue),
    .addrb(rd_ptr),
    .doutb(ram_dout)
  );

  // Accept/pop decisions, read issue and next counts. Reads are issued only
  // while every word already committed to the skid buffer (in flight plus
  // resident, less this cycle's pop) still leaves room for one more.
  always_comb begin
    wr_accept = wr_en & ~full;
    pop       = rd_en & rd_valid;
    skid_push = vld[READ_LATENCY-1];
    inflight  = {SKID_CW{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + SKID_CW'(vld[i]);
    end
    committed = {1'b0, inflight} + {1'b0, skid_count} - CMW'(pop);
    issue = (ram_avail != {CW{1'b0}}) && (committed < CMW'(SKID_DEPTH));
    count_next      = data_count + CW'(wr_accept) - CW'(pop);
    skid_count_next = skid_count + SKID_CW'(skid_push) - SKID_CW'(pop);
  end

  // Write pointer and RAM occupancy; a written word becomes readable one
  // clock after its write so a read never targets the address being written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= {AW{1'b0}};
      wr_pending <= 1'b0;
      ram_avail  <= {CW{1'b0}};
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1'b1);
      end
      wr_pending <= wr_accept;
      ram_avail  <= ram_avail + CW'(wr_pending) - CW'(issue);
    end
  end

  // Read pointer and in-flight valid shift register tracking RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= {AW{1'b0}};
      vld    <= {READ_LATENCY{1'b0}};
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      vld <= (vld << 1'b1) | READ_LATENCY'(issue);
    end
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_wr    <= {SKID_PW{1'b0}};
      skid_rd    <= {SKID_PW{1'b0}};
      skid_count <= {SKID_CW{1'b0}};
    end else begin
      if (skid_push) begin
        skid_wr <= skid_inc(skid_wr);
      end
      if (pop) begin
        skid_rd <= skid_inc(skid_rd);
      end
      skid_count <= skid_count_next;
    end
  end

  // Skid buffer storage captures each word returning from the RAM.
  always_ff @(posedge clk) begin
    if (skid_push) begin
      skid_mem[skid_wr] <= ram_dout;
    end
  end

  // Registered status flags, occupancy and single-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_count <= {CW{1'b0}};
      empty      <= 1'b1;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_count <= count_next;
      empty      <= (count_next == {CW{1'b0}});
      full       <= (count_next == CW'(DEPTH));
      prog_full  <= (count_next >= CW'(PROG_FULL_THRESH));
      prog_empty <= (count_next <= CW'(PROG_EMPTY_THRESH));
      rd_valid   <= (skid_count_next != {SKID_CW{1'b0}});
      overflow   <= wr_en & full;
      underflow  <= rd_en & ~rd_valid;
    end
  end

  assign rd_data = skid_mem[skid_rd];

endmodule

// File: tb/tb_ipbase_fifo_fwft_sync.sv
// Bench for ipbase_fifo_fwft_sync: directed scenarios plus random traffic,
// checked against a queue-based model of occupancy, ordering and head latency.
module tb_ipbase_fifo_fwft_sync;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RL    = 2;
  localparam int PF    = 12;
  localparam int PE    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, prog_full, rd_valid, empty, prog_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] data_count;

  ipbase_fifo_fwft_sync #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .prog_full(prog_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .prog_empty(prog_empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k settles, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int t; } ent_t;
  ent_t q[$];
  bit   exp_ovf = 1'b0;
  bit   exp_udf = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The head word is visible once RL+2 edges have passed since it was accepted.
  function automatic bit head_ready();
    return (q.size() > 0) && (q[0].t + RL + 2 <= cyc);
  endfunction

  // Compare the settled state against the model, then apply one clock of stimulus.
  task automatic step(input bit we, input bit re, input logic [DW-1:0] wd);
    bit hv, full_m;
    hv = head_ready();
    chk("data_count", data_count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("prog_full", prog_full, q.size() >= PF);
    chk("prog_empty", prog_empty, q.size() <= PE);
    chk("rd_valid", rd_valid, hv);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
    if (hv) chk("rd_data", rd_data, q[0].d);
    wr_en = we; rd_en = re; wr_data = wd;
    full_m  = (q.size() == DEPTH);
    exp_ovf = we && full_m;
    exp_udf = re && !hv;
    if (re && hv) void'(q.pop_front());
    if (we && !full_m) q.push_back('{wd, cyc + 1});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, 1'b1, '0);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    do_reset(3);
    // Reset state.
    chk("rst_empty", empty, 1'b1);
    chk("rst_prog_empty", prog_empty, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    step(1'b0, 1'b0, '0);

    // Single word fall-through latency.
    step(1'b1, 1'b0, 32'h0000_00A5);
    chk("lat_count", data_count, 1);
    chk("lat_empty", empty, 1'b0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("lat_valid_n3", rd_valid, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("lat_valid_n4", rd_valid, 1'b1);
    chk("lat_data_n4", rd_data, 32'h0000_00A5);
    drain(20);

    // Fill to full, overflow attempt, read back in order.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));
    chk("fill_full", full, 1'b1);
    step(1'b1, 1'b0, 32'h0000_0099);
    chk("fill_overflow", overflow, 1'b1);
    step(1'b0, 1'b0, '0);
    chk("fill_overflow_once", overflow, 1'b0);
    chk("fill_count", data_count, 16);
    drain(60);

    // Underflow on an empty FIFO.
    step(1'b0, 1'b1, '0);
    chk("udf_pulse", underflow, 1'b1);
    chk("udf_count", data_count, 0);
    step(1'b0, 1'b0, '0);
    chk("udf_once", underflow, 1'b0);

    // Streaming: prefill, then one write and one read every clock.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(32'h1000 + i));
    for (int i = 0; i < RL + 3; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, DW'(32'h2000 + i));
      chk("stream_count", data_count, 6);
    end
    drain(40);

    // Programmable thresholds on fill and drain.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, $urandom);
    chk("pf_at_12", prog_full, 1'b1);
    for (int i = 0; i < RL + 3; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    chk("pe_at_4", prog_empty, 1'b1);
    chk("pe_count", data_count, 4);
    drain(30);

    // Push/pop mix wrapping the pointers several times.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30, $urandom);
    drain(80);

    // Reset with reads in flight and words held in the skid buffer.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(32'hDEAD_0000 + i));
    for (int i = 0; i < RL + 4; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    do_reset(1);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_valid", rd_valid, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(32'hBEEF_0000 + i));
    drain(20);
    step(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
